// File: rtl/clk_div_pkg.sv
// Shared types and defaults for the programmable clock divider.
// Holds width/divisor defaults, the channel phase type and slice helper.
package clk_div_pkg;

    localparam int          WIDTH_DEF = 32;
    localparam int unsigned DIV_DEF   = 32'd50_000_000;

    typedef enum logic {
        PH_LOW  = 1'b0,
        PH_HIGH = 1'b1
    } phase_e;

    // LSB position of channel ch inside a packed per-channel bus
    function automatic int ch_lsb(input int ch, input int width);
        return ch * width;
    endfunction

endpackage

// File: rtl/prog_clk_divider_if.sv
// Control/status bundle between a host and the clock divider.
// Host drives enables, divisors and pulses; divider returns clocks.
interface prog_clk_divider_if
    import clk_div_pkg::*;
#(
    parameter int NCH   = 2,
    parameter int WIDTH = WIDTH_DEF
);

    logic [NCH-1:0]       en;
    logic [NCH*WIDTH-1:0] div_in;
    logic                 div_load;
    logic                 sync;
    logic [NCH-1:0]       clk_out;
    logic [NCH-1:0]       tick;
    logic [NCH-1:0]       div_err;

    modport master (
        output en, div_in, div_load, sync,
        input  clk_out, tick, div_err
    );

    modport slave (
        input  en, div_in, div_load, sync,
        output clk_out, tick, div_err
    );

endinterface

// File: rtl/clk_div_channel.sv
// One divider channel: counter, active/pending divisor, phase.
// Divisor changes take effect only at a falling boundary or when idle.
module clk_div_channel
    import clk_div_pkg::*;
#(
    parameter int               WIDTH       = WIDTH_DEF,
    parameter logic [WIDTH-1:0] DEFAULT_DIV = WIDTH'(DIV_DEF)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] div_in,
    input  logic             div_load,
    input  logic             sync,
    output logic             clk_out,
    output logic             tick,
    output logic             div_err
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    phase_e           phase_q, phase_d;
    logic [WIDTH-1:0] cnt_q,   cnt_d;
    logic [WIDTH-1:0] act_q,   act_d;
    logic [WIDTH-1:0] pend_q,  pend_d;
    logic             pv_q,    pv_d;
    logic             tick_q,  tick_d;

    logic             stall;
    logic             last;
    logic             bound;
    logic             new_pv;
    logic [WIDTH-1:0] new_val;

    assign stall   = sync | ~en | (act_q == '0);
    assign last    = (cnt_q == (act_q - ONE));
    assign bound   = stall | (last & (phase_q == PH_HIGH));
    assign new_pv  = div_load | pv_q;
    assign new_val = div_load ? div_in : pend_q;

    // Next-state: divisor hand-over, counting and phase toggling
    always_comb begin
        phase_d = phase_q;
        cnt_d   = cnt_q;
        act_d   = act_q;
        pend_d  = pend_q;
        pv_d    = pv_q;
        tick_d  = 1'b0;
        if (div_load) begin
            pend_d = div_in;
            pv_d   = 1'b1;
        end
        if (bound && new_pv) begin
            act_d = new_val;
            pv_d  = 1'b0;
        end
        if (stall) begin
            cnt_d   = '0;
            phase_d = PH_LOW;
        end else if (last) begin
            cnt_d = '0;
            case (phase_q)
                PH_LOW: begin
                    phase_d = PH_HIGH;
                    tick_d  = 1'b1;
                end
                default: phase_d = PH_LOW;
            endcase
        end else begin
            cnt_d = cnt_q + ONE;
        end
    end

    // State register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase_q <= PH_LOW;
            cnt_q   <= '0;
            act_q   <= DEFAULT_DIV;
            pend_q  <= '0;
            pv_q    <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            act_q   <= act_d;
            pend_q  <= pend_d;
            pv_q    <= pv_d;
            tick_q  <= tick_d;
        end
    end

    assign clk_out = (phase_q == PH_HIGH);
    assign tick    = tick_q;
    assign div_err = (act_q == '0);

endmodule

// File: rtl/prog_clk_divider.sv
// Multi-channel programmable clock divider top level.
// Replicates one channel per output and broadcasts load/sync.
module prog_clk_divider
    import clk_div_pkg::*;
#(
    parameter int               NCH         = 2,
    parameter int               WIDTH       = WIDTH_DEF,
    parameter logic [WIDTH-1:0] DEFAULT_DIV = WIDTH'(DIV_DEF)
) (
    input logic               clk,
    input logic               rst_n,
    prog_clk_divider_if.slave bus
);

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        clk_div_channel #(
            .WIDTH       (WIDTH),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_ch (
            .clk      (clk),
            .rst_n    (rst_n),
            .en       (bus.en[i]),
            .div_in   (bus.div_in[ch_lsb(i, WIDTH) +: WIDTH]),
            .div_load (bus.div_load),
            .sync     (bus.sync),
            .clk_out  (bus.clk_out[i]),
            .tick     (bus.tick[i]),
            .div_err  (bus.div_err[i])
        );
    end

endmodule

// File: tb/tb_prog_clk_divider.sv
// Directed bench for prog_clk_divider: vector table plus sequences.
// Two 8-bit channels, reset divisor 10.
module tb_prog_clk_divider;

    localparam int NCH = 2;
    localparam int W   = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    prog_clk_divider_if #(.NCH(NCH), .WIDTH(W)) bus ();

    prog_clk_divider #(
        .NCH         (NCH),
        .WIDTH       (W),
        .DEFAULT_DIV (8'd10)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int fails  = 0;

    typedef struct {
        logic        rst_n;
        logic [1:0]  en;
        logic [15:0] div;
        logic        ld;
        logic        sy;
        logic [1:0]  e_clk;
        logic [1:0]  e_tick;
        logic [1:0]  e_err;
    } vec_t;

    vec_t vt[12];

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input logic l, input logic s, input logic [15:0] d);
        bus.div_load = l;
        bus.sync     = s;
        bus.div_in   = d;
        step();
        bus.div_load = 1'b0;
        bus.sync     = 1'b0;
    endtask

    // Step until clk_out[ch] changes to lvl; checks tick on every step
    task automatic wait_edge(input int ch, input logic lvl, input int lim,
                             output int n);
        logic prev;
        logic cur;
        prev = bus.clk_out[ch];
        for (int k = 1; k <= lim; k++) begin
            step();
            cur = bus.clk_out[ch];
            chk($sformatf("tick%0d", ch), 32'(bus.tick[ch]),
                32'(!prev && cur));
            if (cur == lvl && prev != lvl) begin
                n = k;
                return;
            end
            prev = cur;
        end
        n = lim + 1;
        checks++;
        fails++;
        $display("FAIL edge_timeout ch=%0d lvl=%0d got=none exp=edge",
                 ch, lvl);
    endtask

    initial begin
        int n;
        int t0_first, t1_first, t0_cnt, t1_cnt, both_cnt, both_at;

        bus.en       = '0;
        bus.div_in   = '0;
        bus.div_load = 1'b0;
        bus.sync     = 1'b0;

        vt[0]  = '{1'b0, 2'b11, 16'h0000, 1'b1, 1'b1, 2'b00, 2'b00, 2'b00};
        vt[1]  = '{1'b1, 2'b11, 16'h0203, 1'b1, 1'b1, 2'b00, 2'b00, 2'b00};
        vt[2]  = '{1'b1, 2'b11, 16'h0203, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00};
        vt[3]  = '{1'b1, 2'b11, 16'h0203, 1'b0, 1'b0, 2'b10, 2'b10, 2'b00};
        vt[4]  = '{1'b1, 2'b11, 16'h0203, 1'b0, 1'b0, 2'b11, 2'b01, 2'b00};
        vt[5]  = '{1'b1, 2'b11, 16'h0203, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00};
        vt[6]  = '{1'b1, 2'b11, 16'h0203, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00};
        vt[7]  = '{1'b1, 2'b11, 16'h0203, 1'b0, 1'b0, 2'b10, 2'b10, 2'b00};
        vt[8]  = '{1'b1, 2'b11, 16'h0203, 1'b0, 1'b0, 2'b10, 2'b00, 2'b00};
        vt[9]  = '{1'b1, 2'b11, 16'h0203, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00};
        vt[10] = '{1'b1, 2'b11, 16'h0203, 1'b0, 1'b0, 2'b01, 2'b01, 2'b00};
        vt[11] = '{1'b1, 2'b11, 16'h0203, 1'b0, 1'b0, 2'b11, 2'b10, 2'b00};

        // Reset override, then ch0 D=3 / ch1 D=2 cycle by cycle
        for (int i = 0; i < 12; i++) begin
            rst_n        = vt[i].rst_n;
            bus.en       = vt[i].en;
            bus.div_in   = vt[i].div;
            bus.div_load = vt[i].ld;
            bus.sync     = vt[i].sy;
            step();
            chk($sformatf("v%0d_clk", i), 32'(bus.clk_out), 32'(vt[i].e_clk));
            chk($sformatf("v%0d_tick", i), 32'(bus.tick), 32'(vt[i].e_tick));
            chk($sformatf("v%0d_err", i), 32'(bus.div_err), 32'(vt[i].e_err));
        end
        bus.div_load = 1'b0;
        bus.sync     = 1'b0;

        // D=4, reload 2 during the high phase: no truncated half-period
        cyc(1'b1, 1'b1, 16'h0204);
        chk("s32_clk", 32'(bus.clk_out), 32'd0);
        wait_edge(0, 1'b1, 20, n);
        chk("s32_low4", 32'(n), 32'd4);
        step();
        step();
        cyc(1'b1, 1'b0, 16'h0202);
        wait_edge(0, 1'b0, 20, n);
        chk("s32_high_rest", 32'(n), 32'd1);
        wait_edge(0, 1'b1, 20, n);
        chk("s32_low2", 32'(n), 32'd2);
        wait_edge(0, 1'b0, 20, n);
        chk("s32_high2", 32'(n), 32'd2);
        wait_edge(0, 1'b1, 20, n);
        chk("s32_low2b", 32'(n), 32'd2);

        // ch0 D=5, ch1 D=3; sync beats a pending rise
        cyc(1'b1, 1'b1, 16'h0305);
        chk("s33_clk", 32'(bus.clk_out), 32'd0);
        chk("s33_tick", 32'(bus.tick), 32'd0);
        for (int k = 0; k < 4; k++) step();
        cyc(1'b0, 1'b1, 16'h0305);
        chk("s25_clk", 32'(bus.clk_out), 32'd0);
        chk("s25_tick", 32'(bus.tick), 32'd0);
        t0_first = 0; t1_first = 0;
        t0_cnt = 0; t1_cnt = 0; both_cnt = 0; both_at = 0;
        for (int k = 1; k <= 36; k++) begin
            step();
            if (bus.tick[0]) begin
                t0_cnt++;
                if (t0_first == 0) t0_first = k;
            end
            if (bus.tick[1]) begin
                t1_cnt++;
                if (t1_first == 0) t1_first = k;
            end
            if (bus.tick == 2'b11) begin
                both_cnt++;
                both_at = k;
            end
        end
        chk("s33_t0_first", 32'(t0_first), 32'd5);
        chk("s33_t1_first", 32'(t1_first), 32'd3);
        chk("s33_t0_cnt", 32'(t0_cnt), 32'd4);
        chk("s33_t1_cnt", 32'(t1_cnt), 32'd6);
        chk("s33_both_cnt", 32'(both_cnt), 32'd1);
        chk("s33_both_at", 32'(both_at), 32'd15);

        // ch1 divisor 0 stalls after its fall, then D=1
        cyc(1'b1, 1'b0, 16'h0005);
        wait_edge(1, 1'b0, 20, n);
        chk("s34_fall", 32'(n), 32'd5);
        chk("s34_err1", 32'(bus.div_err[1]), 32'd1);
        for (int k = 0; k < 4; k++) begin
            step();
            chk("s34_stall_clk", 32'(bus.clk_out[1]), 32'd0);
            chk("s34_stall_tick", 32'(bus.tick[1]), 32'd0);
        end
        cyc(1'b1, 1'b0, 16'h0105);
        chk("s34_err0", 32'(bus.div_err[1]), 32'd0);
        chk("s34_d1_clk0", 32'(bus.clk_out[1]), 32'd0);
        step();
        chk("s34_d1_clk1", 32'(bus.clk_out[1]), 32'd1);
        chk("s34_d1_tick1", 32'(bus.tick[1]), 32'd1);
        step();
        chk("s34_d1_clk2", 32'(bus.clk_out[1]), 32'd0);
        chk("s34_d1_tick2", 32'(bus.tick[1]), 32'd0);
        step();
        chk("s34_d1_clk3", 32'(bus.clk_out[1]), 32'd1);
        chk("s34_d1_tick3", 32'(bus.tick[1]), 32'd1);

        // en[0] dropped mid-period, then re-enabled
        cyc(1'b1, 1'b1, 16'h0104);
        wait_edge(0, 1'b1, 20, n);
        chk("s35_rise", 32'(n), 32'd4);
        step();
        bus.en = 2'b10;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("s35_off_clk", 32'(bus.clk_out[0]), 32'd0);
            chk("s35_off_tick", 32'(bus.tick[0]), 32'd0);
        end
        bus.en = 2'b11;
        wait_edge(0, 1'b1, 20, n);
        chk("s35_reen", 32'(n), 32'd4);

        // Reset discards a pending divisor of 7
        cyc(1'b1, 1'b0, 16'h0707);
        rst_n = 1'b0;
        step();
        chk("s36_rst_clk", 32'(bus.clk_out), 32'd0);
        chk("s36_rst_tick", 32'(bus.tick), 32'd0);
        chk("s36_rst_err", 32'(bus.div_err), 32'd0);
        rst_n = 1'b1;
        wait_edge(0, 1'b1, 40, n);
        chk("s36_low", 32'(n), 32'd10);
        wait_edge(0, 1'b0, 40, n);
        chk("s36_high", 32'(n), 32'd10);
        wait_edge(0, 1'b1, 40, n);
        chk("s36_low2", 32'(n), 32'd10);

        // Largest divisor for the width
        cyc(1'b1, 1'b1, 16'h01FF);
        wait_edge(0, 1'b1, 600, n);
        chk("smax_low", 32'(n), 32'd255);
        wait_edge(0, 1'b0, 600, n);
        chk("smax_high", 32'(n), 32'd255);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule

// File: doc/prog_clk_divider.md
PROG_CLK_DIVIDER -- requirements
Module: prog_clk_divider

Interface
REQ-001 Parameter NCH, default 2, number of independent divider channels (1..8).
REQ-002 Parameter WIDTH, default 32, divisor/counter width in bits.
REQ-003 Parameter DEFAULT_DIV, default 50000000, active half-period divisor loaded at reset for every channel.
REQ-004 clk  input  1  single system clock; all logic on its rising edge.
REQ-005 rst_n  input  1  reset, synchronous and active-low.
REQ-006 en  input  NCH  per-channel enable, level.
REQ-007 div_in  input  NCH*WIDTH  per-channel divisor; channel i occupies bits [i*WIDTH +: WIDTH].
REQ-008 div_load  input  1  one-cycle pulse; captures div_in for all channels into pending registers.
REQ-009 sync  input  1  one-cycle pulse; phase-aligns all channels.
REQ-010 clk_out  output  NCH  per-channel divided clock, registered.
REQ-011 tick  output  NCH  per-channel one-cycle pulse per full output period, registered.
REQ-012 div_err  output  NCH  per-channel flag, high while active divisor is 0.

Function
REQ-013 Each channel SHALL hold a count register (WIDTH bits), an active divisor, a pending divisor and a pending-valid bit.
REQ-014 With en[i]=1 and active divisor D>=1, count SHALL increment each cycle and wrap 0 after reaching D-1.
REQ-015 On the cycle count==D-1, clk_out[i] SHALL toggle, giving output period 2*D cycles and 50% duty.
REQ-016 tick[i] SHALL be high for exactly the one cycle in which clk_out[i] transitions 0->1, and low otherwise.
REQ-017 D=1 SHALL give clk_out toggling every cycle (period 2) with tick high every second cycle.
REQ-018 div_load SHALL set pending-valid and pending divisor for every channel; a second div_load before application SHALL overwrite the pending value.
REQ-019 A pending divisor SHALL become active only at a period boundary: the cycle clk_out falls (count==D-1 with clk_out=1), or immediately if en[i]=0, D=0, or sync is asserted; pending-valid then clears.
REQ-020 A running channel SHALL never emit a truncated or stretched half-period because of a divisor change.
REQ-021 Active divisor 0 SHALL stall the channel: count 0, clk_out 0, tick 0, div_err 1.
REQ-022 en[i]=0 SHALL clear count and clk_out[i] and tick[i] to 0 on the next edge; re-enable starts a fresh period with clk_out low for D cycles.
REQ-023 sync SHALL clear count, clk_out and tick of all channels on the next edge, applying any pending divisor in the same edge.
REQ-024 div_load and sync in the same cycle SHALL apply the newly loaded div_in immediately.
REQ-025 sync and a wrap in the same cycle SHALL give sync priority; no tick emitted that cycle.
REQ-026 Count comparison SHALL use full WIDTH unsigned arithmetic; D=2^WIDTH-1 SHALL work without overflow.

Reset
REQ-027 With rst_n=0 at a rising edge: count 0, clk_out 0, tick 0, active divisor DEFAULT_DIV, pending-valid 0, div_err 0 (or 1 if DEFAULT_DIV is 0), all channels.
REQ-028 Reset SHALL override en, div_load and sync, and discard any pending divisor mid-operation.

Structure
REQ-029 WIDTH default, DEFAULT_DIV default and the channel-slice helper SHALL live in shared package clk_div_pkg.
REQ-030 One sub-module clk_div_channel SHALL implement one channel (REQ-013..REQ-022); the top SHALL instantiate NCH copies via generate and broadcast div_load and sync.

Verification
REQ-031 Reset then en=1, div_in loaded 3 on ch0 after reset, sync -> clk_out[0] period 6 cycles, 3 high/3 low, tick[0] once per 6 cycles.
REQ-032 ch0 running D=4, div_load with 2 mid-high-phase -> current period completes at 8 cycles, next periods 4 cycles, no glitch.
REQ-033 ch0 D=5, ch1 D=3, sync pulse -> both clk_out 0 next cycle, both rise together 5/3 cycles later respectively, ticks aligned at cycle 15 multiple.
REQ-034 div_load with 0 on ch1 -> ch1 stalls low after its boundary, div_err[1]=1; later load 1 -> toggles every cycle, div_err[1]=0.
REQ-035 en[0] dropped mid-period with D=4 -> clk_out[0]=0 next edge; re-enable -> first rise 4 cycles later.
REQ-036 rst_n=0 during pending load with D=7 -> after release active divisor DEFAULT_DIV (bench overrides to 10), pending discarded, period 20.
